// File: rtl/div_unit.sv
// div_unit: multicycle restoring shift-subtract divider, one quotient bit per
// clock. Answers a start request with div_stop (result on hi_out/lo_out) or
// div_zero (divisor was zero, nothing computed).
// Signed (MIPS DIV) by default. Defining DIV_UNSIGNED_EN adds the
// div_unsigned input, which selects an unsigned (DIVU) division per request.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for div_control; zero divisor answered here
// RUN   | WIDTH iterations of shift / trial-subtract
// FIX   | apply result signs, publish hi/lo, pulse div_stop
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
`ifdef DIV_UNSIGNED_EN
    input  logic             div_unsigned,
`endif
    input  logic             div_control,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_stop,
    output logic             div_zero,
    output logic             div_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO      = '0;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic [CNT_W-1:0] cnt;
    logic             sign_q;
    logic             sign_r;

    logic             signed_op;
    logic             req_zero;
    logic             req_start;
    logic [WIDTH-1:0] abs_dividend;
    logic [WIDTH-1:0] abs_divisor;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             trial_ok;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

`ifdef DIV_UNSIGNED_EN
    assign signed_op = ~div_unsigned;
`else
    assign signed_op = 1'b1;
`endif

    // Requests are only honoured in IDLE; RUN/FIX ignore div_control.
    assign req_zero  = (state == S_IDLE) && div_control && (divisor == ZERO);
    assign req_start = (state == S_IDLE) && div_control && (divisor != ZERO);

    // Magnitudes: the most negative value maps onto itself, which is the
    // correct unsigned magnitude 2^(WIDTH-1).
    assign abs_dividend = (signed_op && dividend[WIDTH-1]) ? (ZERO - dividend) : dividend;
    assign abs_divisor  = (signed_op && divisor[WIDTH-1])  ? (ZERO - divisor)  : divisor;

    // One restoring step. For unsigned operands the shifted remainder can
    // reach 2^WIDTH, beyond what the WIDTH+1 trial can order; when its top
    // bit is set it already exceeds any divisor, so the subtraction is
    // accepted and its low WIDTH bits are exact.
    assign rem_sh   = {rem, quo[WIDTH-1]};
    assign trial    = rem_sh - {1'b0, dvsr};
    assign trial_ok = rem_sh[WIDTH] | ~trial[WIDTH];
    assign rem_next = trial_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], trial_ok};

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req_start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt == CNT_LAST) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_start) begin
                        rem    <= '0;
                        quo    <= abs_dividend;
                        dvsr   <= abs_divisor;
                        cnt    <= CNT_LOAD;
                        sign_q <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        sign_r <= signed_op & dividend[WIDTH-1];
                    end
                end
                S_RUN: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt - CNT_LAST;
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake outputs and published result; pulses default low each cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_out   <= '0;
            lo_out   <= '0;
            div_stop <= 1'b0;
            div_zero <= 1'b0;
            div_busy <= 1'b0;
        end else begin
            div_stop <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_zero) begin
                        div_zero <= 1'b1;
                    end else if (req_start) begin
                        div_busy <= 1'b1;
                    end
                end
                S_FIX: begin
                    lo_out   <= sign_q ? (ZERO - quo) : quo;
                    hi_out   <= sign_r ? (ZERO - rem) : rem;
                    div_stop <= 1'b1;
                    div_busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: reset state, signed sign combinations,
// divide-by-zero trap, overflow case, ignored mid-run request, async abort,
// back-to-back start, and (with DIV_UNSIGNED_EN) the unsigned mode.
module tb_div_unit;

    localparam int WIDTH   = 32;
    localparam int LATENCY = 33;

    logic             clk;
    logic             reset;
    logic             div_control;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             div_stop;
    logic             div_zero;
    logic             div_busy;
    logic             div_unsigned;

    int errors = 0;
    int checks = 0;

    div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef DIV_UNSIGNED_EN
        .div_unsigned(div_unsigned),
`endif
        .div_control (div_control),
        .dividend    (dividend),
        .divisor     (divisor),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .div_stop    (div_stop),
        .div_zero    (div_zero),
        .div_busy    (div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request before the next rising edge and drop it just after.
    task automatic kick(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        dividend    = a;
        divisor     = b;
        div_control = 1'b1;
        @(posedge clk);
        #1;
        div_control = 1'b0;
    endtask

    // Advance (sampling #1 after each edge) until div_stop, bounded.
    task automatic wait_stop(output int cyc, output bit busy_ok, output bit zero_seen);
        cyc       = 0;
        busy_ok   = 1'b1;
        zero_seen = 1'b0;
        while (div_stop !== 1'b1 && cyc < 60) begin
            if (div_busy !== 1'b1) busy_ok = 1'b0;
            if (div_zero !== 1'b0) zero_seen = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #1;
        checks++; if (hi_out !== '0)    begin errors++; $display("FAIL reset_hi got %h want 0", hi_out); end
        checks++; if (lo_out !== '0)    begin errors++; $display("FAIL reset_lo got %h want 0", lo_out); end
        checks++; if (div_stop !== 1'b0) begin errors++; $display("FAIL reset_stop got %b want 0", div_stop); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b want 0", div_zero); end
        checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", div_busy); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_signed;
        logic [WIDTH-1:0] va [4] = '{32'h0000_0007, 32'hFFFF_FFF9, 32'h0000_0007, 32'hFFFF_FFF9};
        logic [WIDTH-1:0] vb [4] = '{32'h0000_0002, 32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        logic [WIDTH-1:0] el [4] = '{32'h0000_0003, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h0000_0003};
        logic [WIDTH-1:0] eh [4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
        int cyc;
        bit busy_ok, zero_seen;
        for (int i = 0; i < 4; i++) begin
            kick(va[i], vb[i]);
            dividend = '1;
            divisor  = '0;
            wait_stop(cyc, busy_ok, zero_seen);
            checks++; if (cyc != LATENCY) begin errors++; $display("FAIL signed%0d_latency got %0d want %0d", i, cyc, LATENCY); end
            checks++; if (!busy_ok || zero_seen) begin errors++; $display("FAIL signed%0d_busy busy_ok=%0d zero_seen=%0d want 1/0", i, busy_ok, zero_seen); end
            checks++; if (lo_out !== el[i]) begin errors++; $display("FAIL signed%0d_lo got %h want %h", i, lo_out, el[i]); end
            checks++; if (hi_out !== eh[i]) begin errors++; $display("FAIL signed%0d_hi got %h want %h", i, hi_out, eh[i]); end
            checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL signed%0d_busy_at_stop got %b want 0", i, div_busy); end
            @(posedge clk);
            #1;
            checks++; if (div_stop !== 1'b0) begin errors++; $display("FAIL signed%0d_stop_width got %b want 0", i, div_stop); end
        end
    endtask

    task automatic test_div_zero;
        logic [WIDTH-1:0] prev_hi;
        logic [WIDTH-1:0] prev_lo;
        bit stop_seen;
        bit busy_seen;
        prev_hi = hi_out;
        prev_lo = lo_out;
        kick(32'h1234_5678, 32'h0000_0000);
        checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL zero_pulse got %b want 1", div_zero); end
        checks++; if (div_stop !== 1'b0) begin errors++; $display("FAIL zero_stop_same_cycle got %b want 0", div_stop); end
        stop_seen = 1'b0;
        busy_seen = div_busy;
        @(posedge clk);
        #1;
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL zero_pulse_width got %b want 0", div_zero); end
        for (int i = 0; i < 40; i++) begin
            if (div_stop !== 1'b0) stop_seen = 1'b1;
            if (div_busy !== 1'b0) busy_seen = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++; if (stop_seen) begin errors++; $display("FAIL zero_no_stop got stop=1 want never"); end
        checks++; if (busy_seen) begin errors++; $display("FAIL zero_no_busy got busy=1 want never"); end
        checks++; if (hi_out !== prev_hi) begin errors++; $display("FAIL zero_hi_hold got %h want %h", hi_out, prev_hi); end
        checks++; if (lo_out !== prev_lo) begin errors++; $display("FAIL zero_lo_hold got %h want %h", lo_out, prev_lo); end
    endtask

    task automatic test_overflow;
        int cyc;
        bit busy_ok, zero_seen;
        kick(32'h8000_0000, 32'hFFFF_FFFF);
        wait_stop(cyc, busy_ok, zero_seen);
        checks++; if (cyc != LATENCY) begin errors++; $display("FAIL ovf_latency got %0d want %0d", cyc, LATENCY); end
        checks++; if (lo_out !== 32'h8000_0000) begin errors++; $display("FAIL ovf_lo got %h want 80000000", lo_out); end
        checks++; if (hi_out !== 32'h0000_0000) begin errors++; $display("FAIL ovf_hi got %h want 00000000", hi_out); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL ovf_zero got %b want 0", div_zero); end
        kick(32'h8000_0000, 32'h0000_0001);
        wait_stop(cyc, busy_ok, zero_seen);
        checks++; if (lo_out !== 32'h8000_0000) begin errors++; $display("FAIL minint_div1_lo got %h want 80000000", lo_out); end
        checks++; if (hi_out !== 32'h0000_0000) begin errors++; $display("FAIL minint_div1_hi got %h want 00000000", hi_out); end
    endtask

    task automatic test_ignore_midrun;
        int cyc;
        bit busy_ok, zero_seen;
        kick(32'd100, 32'd7);
        repeat (4) @(posedge clk);
        kick(32'd9, 32'd3);
        wait_stop(cyc, busy_ok, zero_seen);
        checks++; if (cyc + 5 != LATENCY) begin errors++; $display("FAIL ignore_latency got %0d want %0d", cyc + 5, LATENCY); end
        checks++; if (lo_out !== 32'd14) begin errors++; $display("FAIL ignore_lo got %0d want 14", lo_out); end
        checks++; if (hi_out !== 32'd2) begin errors++; $display("FAIL ignore_hi got %0d want 2", hi_out); end
    endtask

    task automatic test_reset_abort;
        int cyc;
        bit busy_ok, zero_seen;
        bit flag_seen;
        kick(32'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (lo_out !== '0 || hi_out !== '0) begin errors++; $display("FAIL abort_outputs got lo=%h hi=%h want 0/0", lo_out, hi_out); end
        checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", div_busy); end
        @(negedge clk);
        reset = 1'b1;
        flag_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (div_stop !== 1'b0 || div_zero !== 1'b0 || div_busy !== 1'b0) flag_seen = 1'b1;
        end
        checks++; if (flag_seen) begin errors++; $display("FAIL abort_quiet got activity want none"); end
        kick(32'd9, 32'd3);
        wait_stop(cyc, busy_ok, zero_seen);
        checks++; if (cyc != LATENCY) begin errors++; $display("FAIL abort_next_latency got %0d want %0d", cyc, LATENCY); end
        checks++; if (lo_out !== 32'd3) begin errors++; $display("FAIL abort_next_lo got %0d want 3", lo_out); end
        checks++; if (hi_out !== 32'd0) begin errors++; $display("FAIL abort_next_hi got %0d want 0", hi_out); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        bit busy_ok, zero_seen;
        kick(32'd7, 32'd2);
        wait_stop(cyc, busy_ok, zero_seen);
        checks++; if (lo_out !== 32'd3 || hi_out !== 32'd1) begin errors++; $display("FAIL b2b_first got lo=%0d hi=%0d want 3/1", lo_out, hi_out); end
        dividend    = 32'd100;
        divisor     = 32'd7;
        div_control = 1'b1;
        @(posedge clk);
        #1;
        div_control = 1'b0;
        checks++; if (div_busy !== 1'b1 || div_stop !== 1'b0) begin errors++; $display("FAIL b2b_restart got busy=%b stop=%b want 1/0", div_busy, div_stop); end
        wait_stop(cyc, busy_ok, zero_seen);
        checks++; if (cyc != LATENCY) begin errors++; $display("FAIL b2b_latency got %0d want %0d", cyc, LATENCY); end
        checks++; if (lo_out !== 32'd14 || hi_out !== 32'd2) begin errors++; $display("FAIL b2b_second got lo=%0d hi=%0d want 14/2", lo_out, hi_out); end
    endtask

`ifdef DIV_UNSIGNED_EN
    task automatic test_unsigned;
        int cyc;
        bit busy_ok, zero_seen;
        div_unsigned = 1'b1;
        kick(32'hFFFF_FFFE, 32'h0000_0002);
        wait_stop(cyc, busy_ok, zero_seen);
        checks++; if (cyc != LATENCY) begin errors++; $display("FAIL divu_latency got %0d want %0d", cyc, LATENCY); end
        checks++; if (lo_out !== 32'h7FFF_FFFF || hi_out !== 32'h0) begin errors++; $display("FAIL divu_result got lo=%h hi=%h want 7fffffff/0", lo_out, hi_out); end
        kick(32'hFFFF_FFFF, 32'hFFFF_FFFE);
        wait_stop(cyc, busy_ok, zero_seen);
        checks++; if (lo_out !== 32'h1 || hi_out !== 32'h1) begin errors++; $display("FAIL divu_big got lo=%h hi=%h want 1/1", lo_out, hi_out); end
        div_unsigned = 1'b0;
        kick(32'hFFFF_FFFE, 32'h0000_0002);
        wait_stop(cyc, busy_ok, zero_seen);
        checks++; if (lo_out !== 32'hFFFF_FFFF || hi_out !== 32'h0) begin errors++; $display("FAIL divs_result got lo=%h hi=%h want ffffffff/0", lo_out, hi_out); end
    endtask
`endif

    initial begin
        div_control  = 1'b0;
        dividend     = '0;
        divisor      = '0;
        div_unsigned = 1'b0;
        test_reset;
        test_signed;
        test_div_zero;
        test_overflow;
        test_ignore_midrun;
        test_reset_abort;
        test_back_to_back;
`ifdef DIV_UNSIGNED_EN
        test_unsigned;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multicycle signed 32-bit divider; the responder side of the control unit's divide handshake.
- Control unit pulses div_control with operands on A/B. Block answers with div_stop (result ready) or div_zero (divide-by-zero trap).
- Quotient and remainder feed the HI/LO select muxes. External HI/LO registers load them under HiLo_load.
- Restoring shift-subtract algorithm, one quotient bit per cycle.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state when 0.
- div_control  input  1  start request; sampled only in IDLE.
- dividend  input  WIDTH  A operand (rs); sampled on the start edge only.
- divisor  input  WIDTH  B operand (rt); sampled on the start edge only.
- hi_out  output  WIDTH  remainder; holds until the next completion.
- lo_out  output  WIDTH  quotient; holds until the next completion.
- div_stop  output  1  one-cycle pulse: result valid on hi_out/lo_out.
- div_zero  output  1  one-cycle pulse: divisor was zero, division not performed.
- div_busy  output  1  high while a division is in progress.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - hi_out, lo_out, div_stop, div_zero, div_busy all 0.
  - internal remainder/quotient/counter/sign registers cleared.
  - Reset mid-operation aborts with no div_stop and no div_zero.
- FSM states: IDLE, RUN, FIX.
- IDLE, div_control=1, divisor==0:
  - div_zero=1 for exactly one cycle after the edge.
  - state stays IDLE; hi_out/lo_out unchanged.
- IDLE, div_control=1, divisor!=0 (start edge, E0):
  - latch |dividend| and |divisor| (two's-complement absolute value, WIDTH bits, unsigned interpretation).
  - latch sign_q = dividend[MSB] XOR divisor[MSB] and sign_r = dividend[MSB].
  - partial remainder=0, counter=WIDTH, state=RUN, div_busy=1.
- RUN, one iteration per edge E1..E_WIDTH:
  - shift {rem,quo} left by 1.
  - trial = rem_shifted - |divisor|, computed WIDTH+1 bits wide.
  - trial non-negative: rem=trial, quo LSB=1; otherwise quo LSB=0.
  - counter decrements; at counter==1 go to FIX.
- FIX, edge E_WIDTH+1:
  - lo_out = sign_q ? -quo : quo.
  - hi_out = sign_r ? -rem : rem.
  - div_stop=1 for one cycle, div_busy=0, state=IDLE.
- Latency: div_stop is high during the cycle after edge WIDTH+1, i.e. 33 cycles after the start edge for WIDTH=32.
- Rounding: quotient truncates toward zero; remainder carries the dividend's sign (MIPS DIV semantics).
- Overflow: dividend=0x80000000, divisor=-1 gives lo=0x80000000, hi=0. No flag raised.
- div_control while RUN/FIX is ignored; operand changes after E0 have no effect.
- Back-to-back: div_control high on the same edge div_stop drops (state IDLE) starts a new division.
- div_stop and div_zero are never high in the same cycle.

Optional Feature:
- Macro: DIV_UNSIGNED_EN.
- Defined:
  - adds input port div_unsigned (1 bit), sampled on the start edge.
  - when div_unsigned=1: no absolute-value step, sign_q=sign_r=0, operands treated as unsigned (DIVU).
  - zero-divisor check and latency unchanged.
- Undefined: port absent; all divisions are signed.

Test Plan:
- 7/2 (0x7, 0x2): lo=0x00000003, hi=0x00000001; div_stop pulses once, 33 cycles after start; div_busy high in between.
- -7/2 (0xFFFFFFF9, 0x2): lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also 7/-2: lo=0xFFFFFFFD, hi=0x00000001.
- 0x12345678/0: div_zero high one cycle after start; div_stop never asserts; hi/lo keep previous values; div_busy stays 0.
- 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0x00000000 after 33 cycles.
- Start 100/7, pulse div_control again at cycle 5 with 9/3: second request ignored; result is lo=14, hi=2.
- Start 100/7, drive reset=0 at cycle 10 for 1 cycle: outputs 0 immediately (async), div_busy=0, no div_stop. Then 9/3 completes with lo=3, hi=0.
- With DIV_UNSIGNED_EN, div_unsigned=1, 0xFFFFFFFE/2: lo=0x7FFFFFFF, hi=0.
